// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared types and default timing constants for the two-road
//               traffic light controller (light encoding, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // Light head encoding; 2'b11 is never produced.
    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } light_t;

    // Controller phases: main green/yellow, all-red, country green/yellow,
    // all-red back to main.
    typedef enum logic [2:0] {
        MG  = 3'd0,
        MY  = 3'd1,
        AR1 = 3'd2,
        CG  = 3'd3,
        CY  = 3'd4,
        AR2 = 3'd5
    } state_t;

    // Default phase timings, in clock cycles.
    localparam int c_T_MAIN_MIN = 8;
    localparam int c_T_YELLOW   = 2;
    localparam int c_T_ALLRED   = 1;
    localparam int c_T_CTRY_MIN = 2;
    localparam int c_T_CTRY_MAX = 6;

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : 4-bit saturating cycle counter used to time FSM phases.
//               Clear has priority over enable; the count sticks at 15.
// Ports       : clk      - rising-edge clock
//               rst      - synchronous active-high reset (count -> 0)
//               i_clear  - synchronous clear (count -> 0)
//               i_enable - advance the count by one (saturating)
//               o_count  - current count
// Revision    : 1.0 - initial release
// ============================================================================
module phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_enable,
    output logic [3:0] o_count
);

    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= 4'd0;
        end else if (i_enable && (r_count != 4'hF)) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_count = r_count;

endmodule : phase_timer
`default_nettype wire

// File: rtl/traffic_light_top.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_top
// Description : Two-road traffic light controller. Moore FSM that keeps the
//               main road green by default and yields to the country road
//               when country demand is nonzero and at least main demand.
// Ports       : clk             - rising-edge clock
//               rst             - synchronous active-high reset (-> MG)
//               main_traffic    - vehicles waiting on main road (0..7)
//               country_traffic - vehicles waiting on country road (0..7)
//               mainLight       - main-road light head
//               countryLight    - country-road light head
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_top
    import traffic_pkg::*;
#(
    parameter int T_MAIN_MIN = c_T_MAIN_MIN,
    parameter int T_YELLOW   = c_T_YELLOW,
    parameter int T_ALLRED   = c_T_ALLRED,
    parameter int T_CTRY_MIN = c_T_CTRY_MIN,
    parameter int T_CTRY_MAX = c_T_CTRY_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] main_traffic,
    input  logic [2:0] country_traffic,
    output logic [1:0] mainLight,
    output logic [1:0] countryLight
);

    // Last count value of each phase (count starts at 0 on entry).
    localparam logic [3:0] c_MAIN_LAST   = 4'(T_MAIN_MIN - 1);
    localparam logic [3:0] c_YELLOW_LAST = 4'(T_YELLOW - 1);
    localparam logic [3:0] c_ALLRED_LAST = 4'(T_ALLRED - 1);
    localparam logic [3:0] c_CMIN_LAST   = 4'(T_CTRY_MIN - 1);
    localparam logic [3:0] c_CMAX_LAST   = 4'(T_CTRY_MAX - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] w_cnt;
    logic       w_phase_change;
    logic       w_country_wants;
    logic       w_main_wants;

    // Country wins ties; main reclaims only when country is empty or
    // main demand is strictly larger.
    assign w_country_wants = (country_traffic != 3'd0) &&
                             (country_traffic >= main_traffic);
    assign w_main_wants    = (country_traffic == 3'd0) ||
                             (main_traffic > country_traffic);

    // The counter restarts whenever the state is about to change.
    assign w_phase_change = (w_next_state != r_state);

    phase_timer u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_phase_change),
        .i_enable (1'b1),
        .o_count  (w_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MG;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MG: begin
                if ((w_cnt >= c_MAIN_LAST) && w_country_wants) begin
                    w_next_state = MY;
                end
            end
            MY: begin
                if (w_cnt == c_YELLOW_LAST) begin
                    w_next_state = AR1;
                end
            end
            AR1: begin
                if (w_cnt == c_ALLRED_LAST) begin
                    w_next_state = CG;
                end
            end
            CG: begin
                if (((w_cnt >= c_CMIN_LAST) && w_main_wants) ||
                    (w_cnt == c_CMAX_LAST)) begin
                    w_next_state = CY;
                end
            end
            CY: begin
                if (w_cnt == c_YELLOW_LAST) begin
                    w_next_state = AR2;
                end
            end
            AR2: begin
                if (w_cnt == c_ALLRED_LAST) begin
                    w_next_state = MG;
                end
            end
            default: begin
                w_next_state = MG;
            end
        endcase
    end

    // Moore decode from the registered state only.
    always_comb begin
        mainLight    = RED;
        countryLight = RED;
        case (r_state)
            MG:      mainLight    = GREEN;
            MY:      mainLight    = YELLOW;
            CG:      countryLight = GREEN;
            CY:      countryLight = YELLOW;
            default: begin
                mainLight    = RED;
                countryLight = RED;
            end
        endcase
    end

endmodule : traffic_light_top
`default_nettype wire

// File: tb/tb_traffic_light_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_top
// Description : Self-checking bench for traffic_light_top: directed vector
//               table, hand-written corner sequences, and a long sweep plus
//               random run against a phase-schedule reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_top;

    localparam int P_MAIN_MIN = 8;
    localparam int P_YELLOW   = 2;
    localparam int P_ALLRED   = 1;
    localparam int P_CTRY_MIN = 2;
    localparam int P_CTRY_MAX = 6;

    localparam logic [1:0] LG = 2'b00;
    localparam logic [1:0] LY = 2'b01;
    localparam logic [1:0] LR = 2'b10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] main_traffic = 3'd0;
    logic [2:0] country_traffic = 3'd0;
    logic [1:0] mainLight;
    logic [1:0] countryLight;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    traffic_light_top #(
        .T_MAIN_MIN (P_MAIN_MIN),
        .T_YELLOW   (P_YELLOW),
        .T_ALLRED   (P_ALLRED),
        .T_CTRY_MIN (P_CTRY_MIN),
        .T_CTRY_MAX (P_CTRY_MAX)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .main_traffic    (main_traffic),
        .country_traffic (country_traffic),
        .mainLight       (mainLight),
        .countryLight    (countryLight)
    );

    // ------------------------------------------------------------------
    // Reference model: phase index into a fixed six-phase schedule plus
    // the number of cycles already spent in that phase.
    // ------------------------------------------------------------------
    logic [1:0] m_main_of [6] = '{LG, LY, LR, LR, LR, LR};
    logic [1:0] m_ctry_of [6] = '{LR, LR, LR, LG, LY, LR};
    int m_phase   = 0;
    int m_elapsed = 0;

    function automatic void model_edge(input logic r, input int m, input int c);
        bit leave;
        if (r) begin
            m_phase   = 0;
            m_elapsed = 0;
            return;
        end
        case (m_phase)
            0:       leave = (m_elapsed + 1 >= P_MAIN_MIN) && (c > 0) && (c >= m);
            1, 4:    leave = (m_elapsed + 1 == P_YELLOW);
            2, 5:    leave = (m_elapsed + 1 == P_ALLRED);
            default: leave = ((m_elapsed + 1 >= P_CTRY_MIN) && (c == 0 || m > c)) ||
                             (m_elapsed + 1 == P_CTRY_MAX);
        endcase
        if (leave) begin
            m_phase   = (m_phase + 1) % 6;
            m_elapsed = 0;
        end else begin
            m_elapsed = m_elapsed + 1;
        end
    endfunction

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_safety();
        n_cmp++;
        if ((mainLight != LR && countryLight != LR) ||
            mainLight == 2'b11 || countryLight == 2'b11) begin
            n_err++;
            $display("FAIL safety @%0t: main=%b country=%b, expected at least one RED and no 11",
                     $time, mainLight, countryLight);
        end
    endtask

    // One clock: drive on the falling edge, advance the model at the
    // rising edge, sample 1 time unit later.
    task automatic step(input logic r, input logic [2:0] m, input logic [2:0] c);
        @(negedge clk);
        rst             = r;
        main_traffic    = m;
        country_traffic = c;
        @(posedge clk);
        model_edge(r, int'(m), int'(c));
        #1;
        chk("model_main", mainLight, m_main_of[m_phase]);
        chk("model_ctry", countryLight, m_ctry_of[m_phase]);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic       r;
        logic [2:0] m;
        logic [2:0] c;
        logic [1:0] em;
        logic [1:0] ec;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic r, input logic [2:0] m, input logic [2:0] c,
                       input logic [1:0] em, input logic [1:0] ec);
        vec_t v;
        v.r = r; v.m = m; v.c = c; v.em = em; v.ec = ec;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask

    int first_y;
    int back_mg;
    int cg_cycles;
    bit left_mg;

    initial begin
        // Reset for two cycles, then yield after 8 green cycles.
        add(2, 1'b1, 3'd2, 3'd0, LG, LR);
        add(7, 1'b0, 3'd2, 3'd5, LG, LR);
        add(2, 1'b0, 3'd2, 3'd5, LY, LR);
        add(1, 1'b0, 3'd2, 3'd5, LR, LR);
        // Country empties while in CG: minimum 2 green cycles, then exit.
        add(2, 1'b0, 3'd2, 3'd0, LR, LG);
        add(2, 1'b0, 3'd2, 3'd0, LR, LY);
        add(1, 1'b0, 3'd2, 3'd0, LR, LR);
        add(3, 1'b0, 3'd2, 3'd0, LG, LR);
        // Fresh reset, then no country demand: main holds 50 cycles.
        add(2, 1'b1, 3'd2, 3'd0, LG, LR);
        add(50, 1'b0, 3'd2, 3'd0, LG, LR);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].m, tbl[i].c);
            chk($sformatf("vec%0d_main", i), mainLight, tbl[i].em);
            chk($sformatf("vec%0d_ctry", i), countryLight, tbl[i].ec);
        end

        // Forced exit: main=0, country=7 -> CG lasts 6, MG-to-MG is 20.
        step(1'b1, 3'd0, 3'd7);
        back_mg = -1; cg_cycles = 0; left_mg = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            step(1'b0, 3'd0, 3'd7);
            if (countryLight == LG) cg_cycles++;
            if (mainLight != LG) left_mg = 1'b1;
            if (left_mg && mainLight == LG && back_mg < 0) back_mg = i;
            if (back_mg >= 0) break;
        end
        chk_int("forced_cg_len", cg_cycles, 6);
        chk_int("forced_cycle_len", back_mg, 20);

        // Tie 3/3: yellow after 8 cycles; toggling country during MY ignored.
        step(1'b1, 3'd3, 3'd3);
        first_y = -1;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 3'd3, 3'd3);
            if (mainLight == LY) begin
                first_y = i;
                break;
            end
        end
        chk_int("tie_yield_at", first_y, 8);
        step(1'b0, 3'd3, 3'd0);
        chk("tie_my2_main", mainLight, LY);
        step(1'b0, 3'd3, 3'd7);
        chk("tie_ar1_main", mainLight, LR);
        chk("tie_ar1_ctry", countryLight, LR);
        step(1'b0, 3'd3, 3'd0);
        chk("tie_cg_ctry", countryLight, LG);

        // Reset in the middle of CG goes straight to main green.
        step(1'b1, 3'd0, 3'd7);
        chk("midrst_main", mainLight, LG);
        chk("midrst_ctry", countryLight, LR);

        // Sweep: main 0..4 and country 0..7 cycling every clock.
        step(1'b1, 3'd0, 3'd0);
        for (int i = 0; i < 15000; i++) begin
            step(1'b0, 3'(i % 5), 3'(i % 8));
            chk_safety();
        end

        // Random inputs with occasional reset.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 199) == 0), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)));
            chk_safety();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_traffic_light_top
`default_nettype wire
